// File: rtl/ps2_host_tx_if.sv
// Command/status and PS/2 line bundle between the arcade top and the PS/2 host transmitter.
// master = requester/pad side, slave = transmitter.
interface ps2_host_tx_if;
    logic [7:0] TX_DATA;
    logic       TX_START;
    logic       TX_BUSY;
    logic       TX_DONE;
    logic       TX_ERR;
    logic       RX_HOLD;
    logic       PS2_CLK_IN;
    logic       PS2_DATA_IN;
    logic       PS2_CLK_OE;
    logic       PS2_DATA_OE;

    modport master (
        output TX_DATA, TX_START, PS2_CLK_IN, PS2_DATA_IN,
        input  TX_BUSY, TX_DONE, TX_ERR, RX_HOLD, PS2_CLK_OE, PS2_DATA_OE
    );

    modport slave (
        input  TX_DATA, TX_START, PS2_CLK_IN, PS2_DATA_IN,
        output TX_BUSY, TX_DONE, TX_ERR, RX_HOLD, PS2_CLK_OE, PS2_DATA_OE
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-bit frame, ACK); resend on NACK under PS2_TX_RESEND_EN.
// Latency: INHIBIT_CYC + RTS_CYC cycles to first device clock, then paced by the device; DONE/ERR pulse on the first IDLE cycle.
// Backpressure: TX_START is accepted only while TX_BUSY=0; requests while busy are dropped.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 600,
    parameter int RTS_CYC     = 12,
    parameter int TIMEOUT_CYC = 90000
`ifdef PS2_TX_RESEND_EN
    ,
    parameter int MAX_RETRY   = 2
`endif
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    ps2_host_tx_if.slave  bus
);

    localparam int CNT_MAX0 = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_MAX  = (RTS_CYC > CNT_MAX0) ? RTS_CYC : CNT_MAX0;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAITIDLE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      nfall_q, nfall_d;
    logic [7:0]      byte_q, byte_d;
    logic            par_q, par_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_prev_q;
    logic            clk_s, data_s, fall, timeout_hit, nack;

`ifdef PS2_TX_RESEND_EN
    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0]   retry_q, retry_d;
`endif

    assign clk_s       = clk_sync_q[1];
    assign data_s      = data_sync_q[1];
    assign fall        = clk_prev_q & ~clk_s;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nfall_d   = nfall_q;
        byte_d    = byte_q;
        par_d     = par_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        nack      = 1'b0;
`ifdef PS2_TX_RESEND_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                nfall_d   = '0;
                if (bus.TX_START) begin
                    byte_d   = bus.TX_DATA;
                    par_d    = ~^bus.TX_DATA;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
`ifdef PS2_TX_RESEND_EN
                    retry_d  = '0;
`endif
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(INHIBIT_CYC - 1)) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end
            end
            S_RTS: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RTS_CYC - 1)) begin
                    cnt_d    = '0;
                    nfall_d  = '0;
                    clk_oe_d = 1'b0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d = cnt_q + CW'(1);
                if (fall) begin
                    cnt_d   = '0;
                    nfall_d = nfall_q + 4'd1;
                    if (nfall_q < 4'd8) begin
                        data_oe_d = ~byte_q[nfall_q[2:0]];
                    end else if (nfall_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + CW'(1);
                if (fall) begin
                    cnt_d = '0;
                    if (!data_s) begin
                        state_d = S_WAITIDLE;
                    end else begin
                        nack = 1'b1;
                    end
                end
            end
            S_WAITIDLE: begin
                cnt_d = cnt_q + CW'(1);
                if (fall) begin
                    cnt_d = '0;
                end
                if (clk_s && data_s) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase

        // A NACK either restarts the whole frame from the inhibit phase or ends the transfer.
        if (nack) begin
`ifdef PS2_TX_RESEND_EN
            if (retry_q < RW'(MAX_RETRY)) begin
                retry_d   = retry_q + RW'(1);
                cnt_d     = '0;
                nfall_d   = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = S_INHIBIT;
            end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
`else
            state_d = S_IDLE;
            err_d   = 1'b1;
`endif
        end

        if ((state_q == S_SEND || state_q == S_ACK || state_q == S_WAITIDLE) &&
            !fall && state_d == state_q && timeout_hit) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            nfall_q     <= '0;
            byte_q      <= '0;
            par_q       <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nfall_q     <= nfall_d;
            byte_q      <= byte_d;
            par_q       <= par_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_sync_q  <= {clk_sync_q[0], bus.PS2_CLK_IN};
            data_sync_q <= {data_sync_q[0], bus.PS2_DATA_IN};
            clk_prev_q  <= clk_s;
`ifdef PS2_TX_RESEND_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign bus.TX_BUSY     = (state_q != S_IDLE);
    assign bus.RX_HOLD     = (state_q != S_IDLE);
    assign bus.TX_DONE     = done_q;
    assign bus.TX_ERR      = err_q;
    assign bus.PS2_CLK_OE  = clk_oe_q;
    assign bus.PS2_DATA_OE = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a behavioural keyboard that clocks frames in,
// with expected frames/results queued at issue time and checked by independent monitors.
module tb_ps2_host_tx;
    localparam int INH   = 600;
    localparam int RTS   = 12;
    localparam int TO    = 3000;
    localparam int HALF  = 20;
    localparam int LIMIT = 12000;
`ifdef PS2_TX_RESEND_EN
    localparam int NACK_FRAMES = 3;
`else
    localparam int NACK_FRAMES = 1;
`endif
    localparam logic [1:0] R_DONE = 2'b01;
    localparam logic [1:0] R_ERR  = 2'b10;

    logic CLOCK = 1'b0;
    logic RESET_N = 1'b1;
    always #5 CLOCK = ~CLOCK;

    ps2_host_tx_if bus();
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    assign bus.PS2_CLK_IN  = ~(bus.PS2_CLK_OE | dev_clk_low);
    assign bus.PS2_DATA_IN = ~(bus.PS2_DATA_OE | dev_data_low);

    ps2_host_tx #(.TIMEOUT_CYC(TO)) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       par;
    } frame_t;

    frame_t     exp_frames[$];
    logic [1:0] exp_res[$];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned fall4_cyc = 0;
    int unsigned res_cyc = 0;
    int          res_count = 0;
    int          dev_mode = 0;   // 0 ACK, 1 NACK, 2 stop after fall 4, 3 stop after fall 5
    bit          dev_at5 = 1'b0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return (($countones(d) % 2) == 0);
    endfunction

    // Keyboard model: waits for request-to-send, clocks bits in on rising edges, answers ACK/NACK.
    initial begin : device
        forever begin
            logic [9:0] bits;
            int         nf;
            bit         ack;
            frame_t     fr;
            wait (bus.PS2_CLK_IN === 1'b0);
            wait (bus.PS2_CLK_IN === 1'b1 && bus.PS2_DATA_IN === 1'b0);
            bits = '0;
            ack  = (dev_mode == 0);
            nf   = (dev_mode == 2) ? 4 : (dev_mode == 3) ? 5 : 10;
            repeat (HALF) @(negedge CLOCK);
            for (int i = 0; i < nf; i++) begin
                dev_clk_low = 1'b1;
                if (i == 3) fall4_cyc = cyc;
                repeat (HALF) @(negedge CLOCK);
                dev_clk_low = 1'b0;
                bits[i] = bus.PS2_DATA_IN;
                repeat (HALF) @(negedge CLOCK);
            end
            if (dev_mode == 3) begin
                dev_at5 = 1'b1;
            end else if (dev_mode < 2) begin
                if (exp_frames.size() == 0) begin
                    check("unexpected_frame", {22'd0, bits}, 32'hFFFF_FFFF);
                end else begin
                    fr = exp_frames.pop_front();
                    check("frame_data", bits[7:0], fr.d);
                    check("frame_parity", bits[8], fr.par);
                    check("frame_stop", bits[9], 1);
                end
                if (ack) dev_data_low = 1'b1;
                repeat (4) @(negedge CLOCK);
                dev_clk_low = 1'b1;
                repeat (HALF) @(negedge CLOCK);
                dev_clk_low = 1'b0;
                repeat (4) @(negedge CLOCK);
                dev_data_low = 1'b0;
                repeat (HALF) @(negedge CLOCK);
            end
        end
    end

    // Result monitor: every DONE/ERR pulse is matched against the queued outcome.
    initial begin : result_mon
        forever begin
            @(negedge CLOCK);
            if (bus.TX_DONE || bus.TX_ERR) begin
                res_count++;
                res_cyc = cyc;
                if (exp_res.size() == 0)
                    check("unexpected_result", {bus.TX_ERR, bus.TX_DONE}, 0);
                else
                    check("result", {bus.TX_ERR, bus.TX_DONE}, exp_res.pop_front());
                check("idle_at_pulse", {bus.TX_BUSY, bus.RX_HOLD, bus.PS2_CLK_OE, bus.PS2_DATA_OE}, 0);
            end
        end
    end

    // Phase monitor: clock-only inhibit followed by clock+data request-to-send.
    initial begin : phase_mon
        int inh = 0;
        int rts = 0;
        forever begin
            @(negedge CLOCK);
            if (!RESET_N) begin
                inh = 0;
                rts = 0;
            end else if (bus.PS2_CLK_OE && !bus.PS2_DATA_OE) begin
                inh++;
            end else if (bus.PS2_CLK_OE && bus.PS2_DATA_OE) begin
                rts++;
            end else if (rts > 0) begin
                check("inhibit_len", inh, INH);
                check("rts_len", rts, RTS);
                inh = 0;
                rts = 0;
            end
        end
    end

    task automatic start(input logic [7:0] d);
        @(negedge CLOCK);
        bus.TX_DATA  = d;
        bus.TX_START = 1'b1;
        @(negedge CLOCK);
        bus.TX_START = 1'b0;
        check("busy_after_accept", {bus.TX_BUSY, bus.RX_HOLD}, 2'b11);
    endtask

    task automatic wait_result(input int n0, input string name);
        int k;
        k = 0;
        while (res_count == n0 && k < LIMIT) begin
            @(negedge CLOCK);
            #1;
            k++;
        end
        if (res_count == n0) check(name, 0, 1);
    endtask

    task automatic send(input logic [7:0] d, input int mode, input int nframes, input logic [1:0] res);
        int n0;
        frame_t f;
        dev_mode = mode;
        f.d   = d;
        f.par = odd_par(d);
        for (int i = 0; i < nframes; i++) exp_frames.push_back(f);
        exp_res.push_back(res);
        n0 = res_count;
        start(d);
        wait_result(n0, "result_timeout");
    endtask

    initial begin : watchdog
        repeat (90000) @(posedge CLOCK);
        errors++;
        $display("FAIL watchdog: got no end of run expected end within 90000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n0;
        int k;
        int unsigned lat;
        frame_t f;
        bus.TX_DATA  = 8'h00;
        bus.TX_START = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        check("reset_outputs", {bus.TX_BUSY, bus.TX_DONE, bus.TX_ERR, bus.RX_HOLD,
                                bus.PS2_CLK_OE, bus.PS2_DATA_OE}, 0);
        repeat (5) @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLOCK);

        send(8'hED, 0, 1, R_DONE);
        send(8'h07, 0, 1, R_DONE);
        send(8'h00, 0, 1, R_DONE);
        for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 255)), 0, 1, R_DONE);

        // Request while busy must not disturb the frame in flight.
        dev_mode = 0;
        f.d = 8'hF4; f.par = odd_par(8'hF4);
        exp_frames.push_back(f);
        exp_res.push_back(R_DONE);
        n0 = res_count;
        start(8'hF4);
        repeat (INH + RTS + 150) @(negedge CLOCK);
        check("busy_in_send", bus.TX_BUSY, 1);
        bus.TX_DATA  = 8'h55;
        bus.TX_START = 1'b1;
        @(negedge CLOCK);
        bus.TX_START = 1'b0;
        wait_result(n0, "busy_ignore_timeout");

        // Device stops clocking after the 4th fall.
        exp_res.push_back(R_ERR);
        dev_mode = 2;
        n0 = res_count;
        start(8'h3C);
        wait_result(n0, "timeout_err_missing");
        lat = res_cyc - fall4_cyc;
        check("timeout_latency_ok", (lat >= TO && lat <= TO + 6), 1);
        repeat (20) @(negedge CLOCK);

        // Reset in the middle of SEND after the 5th fall.
        dev_mode = 3;
        dev_at5  = 1'b0;
        start(8'h0F);
        k = 0;
        while (!dev_at5 && k < LIMIT) begin
            @(negedge CLOCK);
            k++;
        end
        check("reached_fall5", dev_at5, 1);
        check("data_oe_bit4", bus.PS2_DATA_OE, 1);
        n0 = res_count;
        #2 RESET_N = 1'b0;
        #1;
        check("async_release", {bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.TX_BUSY}, 0);
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (50) @(negedge CLOCK);
        check("no_pulse_after_reset", res_count - n0, 0);
        check("idle_after_reset", bus.TX_BUSY, 0);
        wait (bus.PS2_CLK_IN === 1'b1);
        repeat (2 * HALF) @(negedge CLOCK);

        // NACK: resend count depends on build, then TX_START in the TX_ERR cycle.
        dev_mode = 1;
        f.d = 8'hA5; f.par = odd_par(8'hA5);
        for (int i = 0; i < NACK_FRAMES; i++) exp_frames.push_back(f);
        exp_res.push_back(R_ERR);
        start(8'hA5);
        k = 0;
        while (!bus.TX_ERR && k < LIMIT) begin
            @(negedge CLOCK);
            k++;
        end
        check("nack_err_seen", bus.TX_ERR, 1);
        check("nack_frames_used", exp_frames.size(), 0);
        dev_mode = 0;
        f.d = 8'h5A; f.par = odd_par(8'h5A);
        exp_frames.push_back(f);
        exp_res.push_back(R_DONE);
        n0 = res_count;
        bus.TX_DATA  = 8'h5A;
        bus.TX_START = 1'b1;
        @(negedge CLOCK);
        bus.TX_START = 1'b0;
        check("start_in_err_cycle", bus.TX_BUSY, 1);
        wait_result(n0, "post_nack_timeout");

        repeat (20) @(negedge CLOCK);
        check("frames_drained", exp_frames.size(), 0);
        check("results_drained", exp_res.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
